// File: rtl/fetch_stage_pkg.sv
// Shared fetch/pipeline definitions: widths, reset PC, NOP encoding, FSM states
// and the IF/ID payload.
package fetch_stage_pkg;

    localparam int unsigned PC_W    = 16;
    localparam int unsigned INSTR_W = 16;

    localparam logic [PC_W-1:0]    RESET_PC_DEF = 16'h0000;
    localparam int unsigned        PC_INC_DEF   = 2;
    localparam logic [INSTR_W-1:0] NOP_ENC      = 16'h0000;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        HOLD,
        DROP
    } fetch_state_t;

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [PC_W-1:0]    pc;
        logic               valid;
    } if_id_t;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register; a write with valid=0 inserts a NOP bubble and keeps pc.
module if_id_reg
    import fetch_stage_pkg::*;
#(
    parameter logic [INSTR_W-1:0] NOP_INSTR = NOP_ENC
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   en,
    input  if_id_t d,
    output if_id_t q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '{instr: NOP_INSTR, pc: PC_W'(0), valid: 1'b0};
        end else if (en) begin
            q.valid <= d.valid;
            q.instr <= d.valid ? d.instr : NOP_INSTR;
            if (d.valid) begin
                q.pc <= d.pc;
            end
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, runs a single-outstanding imem handshake,
// drops stale responses after a redirect and writes the IF/ID register.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [PC_W-1:0]    RESET_PC  = RESET_PC_DEF,
    parameter int unsigned        PC_INC    = PC_INC_DEF,
    parameter logic [INSTR_W-1:0] NOP_INSTR = NOP_ENC
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [PC_W-1:0]    PC_out_f,
    input  logic               en_ctrl_f,
    input  logic               freeze_ctrl,
    input  logic               jmp_valid_rf,
    input  logic [PC_W-1:0]    jmp_loc_rf,
    output logic [PC_W-1:0]    PC_ctrl_rf,
    output logic               imem_req,
    output logic [PC_W-1:0]    imem_addr,
    input  logic               imem_ready,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic [INSTR_W-1:0] instr_d,
    output logic [PC_W-1:0]    pc_d,
    output logic               valid_d
);

    localparam logic [PC_W-1:0] INC = PC_W'(PC_INC);

    fetch_state_t       state_q, state_n;
    logic [PC_W-1:0]    pc_q, pc_n;
    logic [PC_W-1:0]    addr_q, addr_n;
    logic               req_q, req_n;
    logic [INSTR_W-1:0] hold_q, hold_n;
    logic [PC_W-1:0]    tgt_q, tgt_n;
    logic               kill_q, kill_n;

    logic [PC_W-1:0]    seq_pc;
    logic [PC_W-1:0]    drop_tgt;
    logic               ifid_en;
    if_id_t             ifid_d, ifid_q;

    // addr_q doubles as the PC of the in-flight (or held) request
    assign seq_pc   = addr_q + INC;
    assign drop_tgt = jmp_valid_rf ? jmp_loc_rf : tgt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
            addr_q  <= PC_W'(0);
            req_q   <= 1'b0;
            hold_q  <= INSTR_W'(0);
            tgt_q   <= PC_W'(0);
            kill_q  <= 1'b0;
        end else begin
            state_q <= state_n;
            pc_q    <= pc_n;
            addr_q  <= addr_n;
            req_q   <= req_n;
            hold_q  <= hold_n;
            tgt_q   <= tgt_n;
            kill_q  <= kill_n;
        end
    end

    always_comb begin
        state_n = state_q;
        pc_n    = pc_q;
        addr_n  = addr_q;
        req_n   = req_q;
        hold_n  = hold_q;
        tgt_n   = tgt_q;
        kill_n  = kill_q;
        ifid_en = en_ctrl_f;
        ifid_d  = '{instr: NOP_INSTR, pc: addr_q, valid: 1'b0};

        case (state_q)
            IDLE: begin
                if (jmp_valid_rf) begin
                    req_n   = 1'b1;
                    addr_n  = jmp_loc_rf;
                    pc_n    = jmp_loc_rf;
                    state_n = WAIT;
                end else if (en_ctrl_f && !freeze_ctrl) begin
                    req_n   = 1'b1;
                    addr_n  = PC_out_f;
                    state_n = WAIT;
                end
            end
            WAIT: begin
                if (imem_ready) begin
                    if (jmp_valid_rf) begin
                        addr_n = jmp_loc_rf;
                        pc_n   = jmp_loc_rf;
                    end else if (en_ctrl_f) begin
                        ifid_d = '{instr: imem_rdata, pc: addr_q, valid: 1'b1};
                        pc_n   = seq_pc;
                        if (freeze_ctrl) begin
                            req_n   = 1'b0;
                            state_n = IDLE;
                        end else begin
                            addr_n = seq_pc;
                        end
                    end else begin
                        hold_n  = imem_rdata;
                        req_n   = 1'b0;
                        state_n = HOLD;
                    end
                end else if (jmp_valid_rf) begin
                    // request must stay stable; remember the target and kill its response
                    tgt_n   = jmp_loc_rf;
                    kill_n  = 1'b1;
                    state_n = DROP;
                end
            end
            DROP: begin
                tgt_n = drop_tgt;
                if (imem_ready && kill_q) begin
                    req_n   = 1'b1;
                    addr_n  = drop_tgt;
                    pc_n    = drop_tgt;
                    kill_n  = 1'b0;
                    state_n = WAIT;
                end
            end
            HOLD: begin
                if (jmp_valid_rf) begin
                    req_n   = 1'b1;
                    addr_n  = jmp_loc_rf;
                    pc_n    = jmp_loc_rf;
                    state_n = WAIT;
                end else if (en_ctrl_f) begin
                    ifid_d = '{instr: hold_q, pc: addr_q, valid: 1'b1};
                    pc_n   = seq_pc;
                    if (freeze_ctrl) begin
                        state_n = IDLE;
                    end else begin
                        req_n   = 1'b1;
                        addr_n  = seq_pc;
                        state_n = WAIT;
                    end
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    if_id_reg #(
        .NOP_INSTR(NOP_INSTR)
    ) u_if_id (
        .clk(clk),
        .rst(rst),
        .en (ifid_en),
        .d  (ifid_d),
        .q  (ifid_q)
    );

    assign PC_ctrl_rf = pc_q;
    assign imem_req   = req_q;
    assign imem_addr  = addr_q;
    assign instr_d    = ifid_q.instr;
    assign pc_d       = ifid_q.pc;
    assign valid_d    = ifid_q.valid;

endmodule
